// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end in front of the instruction cache.
// Owns the PC, keeps at most one ibus request outstanding, and buffers the
// returned words in a QUEUE_DEPTH-entry circular queue that decode drains
// with a valid/ready handshake. A redirect flushes the queue and drops any
// response that is still in flight.
//
// Build option: define FETCH_MISALIGN_TRAP_EN to turn a misaligned PC into a
// single marker entry (out_misalign=1) instead of a bus request. Without it,
// the fetch address is the PC with its low two bits forced to zero, and
// out_misalign is tied to 0.

package fetch_unit_pkg;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

endpackage

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [63:0] PC_RESET    = 64'h0000_0000_8000_0000,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output ibus_req_t   ireq,
  input  ibus_resp_t  iresp,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_misalign
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [63:0] pc_q, pc_d;
  ibus_req_t  ireq_q, ireq_d;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] count_after;

  // Queue storage; only written on push, never reset (count guards reads).
  logic [QUEUE_DEPTH-1:0][63:0] qpc_q;
  logic [QUEUE_DEPTH-1:0][31:0] qins_q;

  logic        push;
  logic        pop;
  logic [63:0] push_pc;
  logic [31:0] push_instr;
  logic [63:0] pc_inc;
  logic [63:0] next_addr;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic [QUEUE_DEPTH-1:0] qmis_q;
  logic                   push_mis;
  // Set once a misalign marker is queued; holds fetch off until a redirect.
  logic                   stall_q, stall_d;
`endif

  // addr_ok plays no part in completion; only data_ok ends a request.
  logic unused_addr_ok;
  assign unused_addr_ok = iresp.addr_ok;

  // A redirect kills any pop in the same cycle along with the queue contents.
  assign pop         = out_valid & out_ready & ~redirect_valid;
  assign pc_inc      = pc_q + 64'd4;
  // Occupancy after this cycle's push (only meaningful when pushing).
  assign count_after = count_q + CNT_W'(1) - CNT_W'(pop);

`ifdef FETCH_MISALIGN_TRAP_EN
  assign next_addr = pc_inc;
`else
  assign next_addr = {pc_inc[63:2], 2'b00};
`endif

  // Next-state, PC and bus-request logic for the fetch FSM.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ireq_d     = ireq_q;
    push       = 1'b0;
    push_pc    = ireq_q.addr;
    push_instr = iresp.data;
`ifdef FETCH_MISALIGN_TRAP_EN
    push_mis   = 1'b0;
    stall_d    = stall_q & ~redirect_valid;
`endif
    unique case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end else if (count_q < DEPTH_C) begin
`ifdef FETCH_MISALIGN_TRAP_EN
          if (pc_q[1:0] != 2'b00) begin
            // Misaligned: queue one marker in place of a bus request.
            if (!stall_q) begin
              push       = 1'b1;
              push_pc    = pc_q;
              push_instr = '0;
              push_mis   = 1'b1;
              stall_d    = 1'b1;
            end
          end else begin
            ireq_d  = '{valid: 1'b1, addr: pc_q};
            state_d = REQ;
          end
`else
          ireq_d  = '{valid: 1'b1, addr: {pc_q[63:2], 2'b00}};
          state_d = REQ;
`endif
        end
      end
      REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (iresp.data_ok) begin
            // Response lands with the redirect: drop it, request is done.
            ireq_d.valid = 1'b0;
            state_d      = IDLE;
          end else begin
            // Keep the outstanding request on the bus until it completes.
            state_d = DISCARD;
          end
        end else if (iresp.data_ok) begin
          push = 1'b1;
          pc_d = pc_inc;
          // Chain the next fetch only if a slot remains to reserve for it.
          if (count_after < DEPTH_C) begin
            ireq_d.addr = next_addr;
          end else begin
            ireq_d.valid = 1'b0;
            state_d      = IDLE;
          end
        end
      end
      DISCARD: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end
        if (iresp.data_ok) begin
          ireq_d.valid = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        ireq_d.valid = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  // Queue pointer and occupancy update; a redirect empties the queue.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (redirect_valid) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= PC_RESET;
      ireq_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ireq_q  <= ireq_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Queue payload write at the tail on push.
  always_ff @(posedge clk) begin
    if (push) begin
      qpc_q[tail_q]  <= push_pc;
      qins_q[tail_q] <= push_instr;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Misalign marker bit per entry plus the stall flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= 1'b0;
    end else begin
      stall_q <= stall_d;
    end
    if (push) begin
      qmis_q[tail_q] <= push_mis;
    end
  end

  assign out_misalign = out_valid & qmis_q[head_q];
`else
  assign out_misalign = 1'b0;
`endif

  assign ireq      = ireq_q;
  assign out_valid = (count_q != '0);
  assign out_pc    = qpc_q[head_q];
  assign out_instr = qins_q[head_q];

  // Slot reservation means a push can never land on a full queue.
  assert property (@(posedge clk) disable iff (!reset) push |-> (count_q != DEPTH_C));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a simple cache model answers every valid
// request with data = addr[31:0] ^ 32'hC0DE_0000 whenever dok is high.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  ibus_req_t   ireq;
  ibus_resp_t  iresp;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_misalign;
  logic        dok;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign iresp = '{addr_ok: ireq.valid, data_ok: dok & ireq.valid,
                   data: ireq.addr[31:0] ^ 32'hC0DE_0000};

  fetch_unit dut (
    .clk(clk), .reset(reset), .ireq(ireq), .iresp(iresp),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .out_misalign(out_misalign)
  );

  function automatic logic [31:0] exp_instr(input logic [63:0] a);
    return a[31:0] ^ 32'hC0DE_0000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; dok = 1'b0; out_ready = 1'b0;
    step(); step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; dok = 1'b0; out_ready = 1'b0;
    step(); step();
    checks++; if (ireq.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ireq.valid); end
    checks++; if (ireq.addr !== 64'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", ireq.addr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    reset = 1'b1;
    step();
    checks++; if (ireq.valid !== 1'b1 || ireq.addr !== BASE) begin errors++; $display("FAIL first_req: got v=%b a=%h want v=1 a=%h", ireq.valid, ireq.addr, BASE); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL first_out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_stream();
    logic [63:0] ea, ep;
    do_reset(); dok = 1'b1; out_ready = 1'b1;
    step();
    checks++; if (ireq.valid !== 1'b1 || ireq.addr !== BASE) begin errors++; $display("FAIL stream_req0: got v=%b a=%h want a=%h", ireq.valid, ireq.addr, BASE); end
    for (int k = 0; k < 4; k++) begin
      step();
      ea = BASE + 64'(4 * (k + 1));
      ep = BASE + 64'(4 * k);
      checks++; if (ireq.valid !== 1'b1 || ireq.addr !== ea) begin errors++; $display("FAIL stream_req%0d: got v=%b a=%h want a=%h", k + 1, ireq.valid, ireq.addr, ea); end
      checks++; if (out_valid !== 1'b1 || out_pc !== ep) begin errors++; $display("FAIL stream_pc%0d: got v=%b pc=%h want pc=%h", k, out_valid, out_pc, ep); end
      checks++; if (out_instr !== exp_instr(ep)) begin errors++; $display("FAIL stream_instr%0d: got %h want %h", k, out_instr, exp_instr(ep)); end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] ea;
    do_reset(); dok = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      ea = BASE + 64'(4 * k);
      checks++; if (ireq.valid !== 1'b1 || ireq.addr !== ea) begin errors++; $display("FAIL bp_req%0d: got v=%b a=%h want a=%h", k, ireq.valid, ireq.addr, ea); end
    end
    step();
    checks++; if (ireq.valid !== 1'b0) begin errors++; $display("FAIL bp_stop: got v=%b want 0", ireq.valid); end
    checks++; if (out_valid !== 1'b1 || out_pc !== BASE) begin errors++; $display("FAIL bp_head: got v=%b pc=%h want pc=%h", out_valid, out_pc, BASE); end
    step(); step();
    checks++; if (ireq.valid !== 1'b0) begin errors++; $display("FAIL bp_idle: got v=%b want 0", ireq.valid); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    checks++; if (out_pc !== BASE + 64'd4) begin errors++; $display("FAIL bp_pop: got pc=%h want %h", out_pc, BASE + 64'd4); end
    step();
    checks++; if (ireq.valid !== 1'b1 || ireq.addr !== BASE + 64'h10) begin errors++; $display("FAIL bp_refill: got v=%b a=%h want a=%h", ireq.valid, ireq.addr, BASE + 64'h10); end
    step();
    checks++; if (ireq.valid !== 1'b0) begin errors++; $display("FAIL bp_one_only: got v=%b want 0", ireq.valid); end
    checks++; if (out_pc !== BASE + 64'd4) begin errors++; $display("FAIL bp_head2: got pc=%h want %h", out_pc, BASE + 64'd4); end
  endtask

  task automatic test_redirect_discard();
    localparam logic [63:0] RPC = 64'h0000_0000_8000_1000;
    do_reset(); dok = 1'b1; out_ready = 1'b0;
    step(); step(); step();
    checks++; if (ireq.addr !== BASE + 64'd8) begin errors++; $display("FAIL rd_pre: got a=%h want %h", ireq.addr, BASE + 64'd8); end
    dok = 1'b0; step();
    redirect_valid = 1'b1; redirect_pc = RPC; step(); redirect_valid = 1'b0;
    checks++; if (ireq.valid !== 1'b1 || ireq.addr !== BASE + 64'd8) begin errors++; $display("FAIL rd_hold: got v=%b a=%h want a=%h", ireq.valid, ireq.addr, BASE + 64'd8); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rd_flush: got %b want 0", out_valid); end
    step();
    checks++; if (ireq.valid !== 1'b1 || ireq.addr !== BASE + 64'd8) begin errors++; $display("FAIL rd_hold2: got v=%b a=%h want a=%h", ireq.valid, ireq.addr, BASE + 64'd8); end
    dok = 1'b1; step();
    checks++; if (ireq.valid !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rd_drop: got v=%b ov=%b want 0 0", ireq.valid, out_valid); end
    step();
    checks++; if (ireq.valid !== 1'b1 || ireq.addr !== RPC) begin errors++; $display("FAIL rd_new: got v=%b a=%h want a=%h", ireq.valid, ireq.addr, RPC); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rd_gap: got %b want 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== RPC || out_instr !== exp_instr(RPC)) begin errors++; $display("FAIL rd_entry: got v=%b pc=%h i=%h want pc=%h i=%h", out_valid, out_pc, out_instr, RPC, exp_instr(RPC)); end
  endtask

  task automatic test_redirect_dataok();
    localparam logic [63:0] RPC = 64'h0000_0000_8000_2000;
    do_reset(); dok = 1'b1; out_ready = 1'b1;
    step(); step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rdo_pre: got %b want 1", out_valid); end
    redirect_valid = 1'b1; redirect_pc = RPC; step(); redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || ireq.valid !== 1'b0) begin errors++; $display("FAIL rdo_empty: got ov=%b v=%b want 0 0", out_valid, ireq.valid); end
    step();
    checks++; if (ireq.valid !== 1'b1 || ireq.addr !== RPC) begin errors++; $display("FAIL rdo_new: got v=%b a=%h want a=%h", ireq.valid, ireq.addr, RPC); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rdo_gap: got %b want 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== RPC) begin errors++; $display("FAIL rdo_entry: got v=%b pc=%h want pc=%h", out_valid, out_pc, RPC); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] ep;
    do_reset(); dok = 1'b1; out_ready = 1'b0;
    repeat (5) step();
    checks++; if (ireq.valid !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_full: got v=%b ov=%b want 0 1", ireq.valid, out_valid); end
    ep = BASE; out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      checks++; if (out_valid !== 1'b1 || out_pc !== ep) begin errors++; $display("FAIL b2b_pc%0d: got v=%b pc=%h want pc=%h", k, out_valid, out_pc, ep); end
      checks++; if (out_instr !== exp_instr(ep)) begin errors++; $display("FAIL b2b_instr%0d: got %h want %h", k, out_instr, exp_instr(ep)); end
      ep = ep + 64'd4;
      step();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;
    do_reset(); dok = 1'b1; out_ready = 1'b1;
    step();
    redirect_valid = 1'b1; redirect_pc = TOP; step(); redirect_valid = 1'b0;
    step();
    checks++; if (ireq.valid !== 1'b1 || ireq.addr !== TOP) begin errors++; $display("FAIL wrap_top: got v=%b a=%h want a=%h", ireq.valid, ireq.addr, TOP); end
    step();
    checks++; if (ireq.valid !== 1'b1 || ireq.addr !== 64'h0) begin errors++; $display("FAIL wrap_zero: got v=%b a=%h want 0", ireq.valid, ireq.addr); end
    checks++; if (out_pc !== TOP || out_instr !== exp_instr(TOP)) begin errors++; $display("FAIL wrap_entry: got pc=%h i=%h want pc=%h i=%h", out_pc, out_instr, TOP, exp_instr(TOP)); end
  endtask

  task automatic test_misalign();
    do_reset(); dok = 1'b0; out_ready = 1'b0;
    step();
    redirect_valid = 1'b1; redirect_pc = BASE + 64'd2; step(); redirect_valid = 1'b0;
    dok = 1'b1; step();
    step();
`ifdef FETCH_MISALIGN_TRAP_EN
    checks++; if (ireq.valid !== 1'b0) begin errors++; $display("FAIL mis_noreq: got v=%b want 0", ireq.valid); end
    checks++; if (out_valid !== 1'b1 || out_pc !== BASE + 64'd2 || out_instr !== 32'h0 || out_misalign !== 1'b1) begin errors++; $display("FAIL mis_marker: got v=%b pc=%h i=%h m=%b want pc=%h i=0 m=1", out_valid, out_pc, out_instr, out_misalign, BASE + 64'd2); end
    step(); step();
    checks++; if (ireq.valid !== 1'b0) begin errors++; $display("FAIL mis_stall: got v=%b want 0", ireq.valid); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || ireq.valid !== 1'b0) begin errors++; $display("FAIL mis_single: got ov=%b v=%b want 0 0", out_valid, ireq.valid); end
    redirect_valid = 1'b1; redirect_pc = BASE + 64'h100; step(); redirect_valid = 1'b0;
    step();
    checks++; if (ireq.valid !== 1'b1 || ireq.addr !== BASE + 64'h100) begin errors++; $display("FAIL mis_resume: got v=%b a=%h want a=%h", ireq.valid, ireq.addr, BASE + 64'h100); end
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== BASE + 64'h100 || out_misalign !== 1'b0) begin errors++; $display("FAIL mis_entry: got v=%b pc=%h m=%b want pc=%h m=0", out_valid, out_pc, out_misalign, BASE + 64'h100); end
`else
    checks++; if (ireq.valid !== 1'b1 || ireq.addr !== BASE) begin errors++; $display("FAIL mis_align: got v=%b a=%h want a=%h", ireq.valid, ireq.addr, BASE); end
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== BASE || out_misalign !== 1'b0) begin errors++; $display("FAIL mis_entry: got v=%b pc=%h m=%b want pc=%h m=0", out_valid, out_pc, out_misalign, BASE); end
    checks++; if (ireq.addr !== BASE + 64'd4) begin errors++; $display("FAIL mis_next: got a=%h want %h", ireq.addr, BASE + 64'd4); end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_discard();
    test_redirect_dataok();
    test_back_to_back();
    test_wrap();
    test_misalign();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
